// File: rtl/vga_fb_arbiter_if.sv
// Host access bus of the VGA frame-buffer arbiter.
// master: host side (drives request), slave: arbiter side (returns ack/data).
interface vga_fb_arbiter_if #(
  parameter int unsigned AW = 19,
  parameter int unsigned DW = 16
);
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_ack;
  logic [DW-1:0] h_rdata;

  modport master (
    output h_req, h_we, h_addr, h_wdata,
    input  h_ack, h_rdata
  );

  modport slave (
    input  h_req, h_we, h_addr, h_wdata,
    output h_ack, h_rdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer SRAM arbiter: line prefetch (priority) vs. host port.
// Prefetch fills the double-buffered line buffer one line ahead of display.
// Optional build macro VGA_ARB_OVF_EN adds the sticky fetch-overrun flag
// (o_fetch_ovf) and its clear input (i_ovf_clr).
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | no access; start pending fetch first, else host access
// S_FETCH | one line-word SRAM read per cycle
// S_DRAIN | final line-buffer write, advance to next line
// S_HOST  | host SRAM access on the bus
// S_HACK  | host ack pulse, read data returned
module vga_fb_arbiter #(
  parameter int unsigned AW         = 19,
  parameter int unsigned DW         = 16,
  parameter int unsigned LINE_WORDS = 50,
  parameter int unsigned LINES      = 600
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_hstart,
  input  logic          i_vstart,
  input  logic          i_vnotactive,
  vga_fb_arbiter_if.slave io_host,
  output logic          o_m_cs,
  output logic          o_m_we,
  output logic [AW-1:0] o_m_addr,
  output logic [DW-1:0] o_m_wdata,
  input  logic [DW-1:0] i_m_rdata,
  output logic          o_lb_we,
  output logic          o_lb_bank,
  output logic [5:0]    o_lb_addr,
  output logic [DW-1:0] o_lb_wdata
`ifdef VGA_ARB_OVF_EN
  ,
  output logic          o_fetch_ovf,
  input  logic          i_ovf_clr
`endif
);

  localparam int unsigned CW = $clog2(LINES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_HOST  = 3'd3,
    S_HACK  = 3'd4
  } state_t;

  state_t        r_state;
  logic          r_fetch_pend;
  logic [AW-1:0] r_line_base;
  logic [CW-1:0] r_line_cnt;
  logic [5:0]    r_word;
  logic          r_lb_bank;
  logic          r_m_cs;
  logic          r_m_we;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_wdata;
  logic          r_lb_we;
  logic [5:0]    r_lb_addr;
  logic          r_h_ack;

  logic w_busy;
  logic w_hs_fetch;
  logic w_fetch_go;
  logic w_host_go;
  logic w_word_last;

  assign w_busy      = (r_state == S_FETCH) || (r_state == S_DRAIN);
  // vstart in the same cycle overrides any hstart request
  assign w_hs_fetch  = i_hstart && !i_vstart && !i_vnotactive &&
                       (r_line_cnt < CW'(LINES));
  // a vstart restarts the frame, so never launch a burst at the stale base
  assign w_fetch_go  = (r_state == S_IDLE) && r_fetch_pend && !i_vstart;
  assign w_host_go   = (r_state == S_IDLE) && !r_fetch_pend && io_host.h_req;
  assign w_word_last = (r_word == 6'(LINE_WORDS - 1));

  // Line bookkeeping: pending fetch, line base address, line count, fill bank
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pend <= 1'b0;
      r_line_base  <= '0;
      r_line_cnt   <= '0;
      r_lb_bank    <= 1'b0;
    end else if (i_vstart) begin
      r_fetch_pend <= 1'b1;
      r_line_base  <= '0;
      r_line_cnt   <= '0;
      r_lb_bank    <= 1'b0;
    end else begin
      // a new request arriving on the FETCH entry cycle must not be lost
      if (w_hs_fetch) begin
        r_fetch_pend <= 1'b1;
        r_lb_bank    <= ~r_lb_bank;
      end else if (w_fetch_go) begin
        r_fetch_pend <= 1'b0;
      end
      if (r_state == S_DRAIN) begin
        r_line_base <= r_line_base + AW'(LINE_WORDS);
        if (r_line_cnt < CW'(LINES))
          r_line_cnt <= r_line_cnt + CW'(1);
      end
    end
  end

  // Arbiter FSM with registered SRAM, line-buffer and host-ack outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_word    <= '0;
      r_m_cs    <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_lb_we   <= 1'b0;
      r_lb_addr <= '0;
      r_h_ack   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_lb_we <= 1'b0;
          r_h_ack <= 1'b0;
          if (w_fetch_go) begin
            r_state  <= S_FETCH;
            r_word   <= '0;
            r_m_cs   <= 1'b1;
            r_m_we   <= 1'b0;
            r_m_addr <= r_line_base;
          end else if (w_host_go) begin
            r_state   <= S_HOST;
            r_m_cs    <= 1'b1;
            r_m_we    <= io_host.h_we;
            r_m_addr  <= io_host.h_addr;
            r_m_wdata <= io_host.h_wdata;
          end
        end
        S_FETCH: begin
          if (i_vstart) begin
            // frame restart: drop the burst, the new row-0 fetch follows
            r_state <= S_IDLE;
            r_m_cs  <= 1'b0;
            r_lb_we <= 1'b0;
          end else begin
            r_lb_we   <= 1'b1;
            r_lb_addr <= r_word;
            if (w_word_last) begin
              r_state <= S_DRAIN;
              r_m_cs  <= 1'b0;
            end else begin
              r_word   <= r_word + 6'd1;
              r_m_addr <= r_line_base + AW'(r_word) + AW'(1);
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_IDLE;
          r_lb_we <= 1'b0;
        end
        S_HOST: begin
          r_state <= S_HACK;
          r_m_cs  <= 1'b0;
          r_m_we  <= 1'b0;
          r_h_ack <= 1'b1;
        end
        S_HACK: begin
          r_state <= S_IDLE;
          r_h_ack <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_m_cs  <= 1'b0;
          r_m_we  <= 1'b0;
          r_lb_we <= 1'b0;
          r_h_ack <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_ARB_OVF_EN
  logic r_fetch_ovf;

  // Sticky overrun: hstart while the previous line is still pending or in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_fetch_ovf <= 1'b0;
    else if (i_hstart && (r_fetch_pend || w_busy))
      r_fetch_ovf <= 1'b1;
    else if (i_ovf_clr)
      r_fetch_ovf <= 1'b0;
  end

  assign o_fetch_ovf = r_fetch_ovf;
`endif

  // SRAM read data arrives one cycle after the read issue, which is exactly
  // the cycle carrying lb_we or h_ack; gate it so idle outputs stay at zero.
  assign o_m_cs          = r_m_cs;
  assign o_m_we          = r_m_we;
  assign o_m_addr        = r_m_addr;
  assign o_m_wdata       = r_m_wdata;
  assign o_lb_we         = r_lb_we;
  assign o_lb_bank       = r_lb_bank;
  assign o_lb_addr       = r_lb_addr;
  assign o_lb_wdata      = r_lb_we ? i_m_rdata : '0;
  assign io_host.h_ack   = r_h_ack;
  assign io_host.h_rdata = r_h_ack ? i_m_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: SRAM model, line-buffer and host
// scoreboards, latency and frame-boundary checks.
module tb_vga_fb_arbiter;
  localparam int AW    = 19;
  localparam int DW    = 16;
  localparam int LW    = 50;
  localparam int LINES = 600;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hstart = 1'b0;
  logic          vstart = 1'b0;
  logic          vnotactive = 1'b0;
  logic          m_cs, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          lb_we, lb_bank;
  logic [5:0]    lb_addr;
  logic [DW-1:0] lb_wdata;
`ifdef VGA_ARB_OVF_EN
  logic          fetch_ovf;
  logic          ovf_clr = 1'b0;
`endif

  vga_fb_arbiter_if #(.AW(AW), .DW(DW)) hif ();

  vga_fb_arbiter #(.AW(AW), .DW(DW), .LINE_WORDS(LW), .LINES(LINES)) dut (
`ifdef VGA_ARB_OVF_EN
    .o_fetch_ovf  (fetch_ovf),
    .i_ovf_clr    (ovf_clr),
`endif
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_hstart     (hstart),
    .i_vstart     (vstart),
    .i_vnotactive (vnotactive),
    .io_host      (hif.slave),
    .o_m_cs       (m_cs),
    .o_m_we       (m_we),
    .o_m_addr     (m_addr),
    .o_m_wdata    (m_wdata),
    .i_m_rdata    (m_rdata),
    .o_lb_we      (lb_we),
    .o_lb_bank    (lb_bank),
    .o_lb_addr    (lb_addr),
    .o_lb_wdata   (lb_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cs_cycles = 0;

  typedef struct packed {
    logic          bank;
    logic [5:0]    addr;
    logic [DW-1:0] data;
  } lbw_t;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] rdata;
  } hx_t;

  lbw_t          lbq[$];
  hx_t           hq[$];
  logic [DW-1:0] ref_wr[int];
  logic [DW-1:0] sram[0:32767];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int a);
    logic [31:0] p;
    p = a * 32'h9E37;
    return p[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [DW-1:0] exp_mem(input int a);
    if (ref_wr.exists(a)) return ref_wr[a];
    return pat(a);
  endfunction

  // SRAM model: contents preloaded with a pattern while reset is held
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32768; i++) sram[i] <= pat(i);
      m_rdata <= '0;
    end else if (m_cs) begin
      if (m_we) sram[m_addr[14:0]] <= m_wdata;
      else      m_rdata <= sram[m_addr[14:0]];
    end
  end

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_cs) cs_cycles <= cs_cycles + 1;
      if (lb_we) begin
        chk("lb_q_avail", 32'(lbq.size() != 0), 32'd1);
        if (lbq.size() != 0) begin
          chk("lb_bank", 32'(lb_bank), 32'(lbq[0].bank));
          chk("lb_addr", 32'(lb_addr), 32'(lbq[0].addr));
          chk("lb_data", 32'(lb_wdata), 32'(lbq[0].data));
          void'(lbq.pop_front());
        end
      end
      if (hif.h_ack) begin
        chk("hq_avail", 32'(hq.size() != 0), 32'd1);
        if (hq.size() != 0) begin
          if (!hq[0].we) chk("h_rdata", 32'(hif.h_rdata), 32'(hq[0].rdata));
          void'(hq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input int base, input logic bank, input int n);
    for (int i = 0; i < n; i++)
      lbq.push_back(lbw_t'{bank, 6'(i), exp_mem(base + i)});
  endtask

  task automatic pulse_vstart();
    vstart = 1'b1;
    tick();
    vstart = 1'b0;
  endtask

  task automatic pulse_hstart(input logic vna);
    hstart = 1'b1;
    vnotactive = vna;
    tick();
    hstart = 1'b0;
    vnotactive = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (lbq.size() != 0 && k < 300) begin
      tick();
      k++;
    end
    chk("drain", 32'(lbq.size()), 32'd0);
    tick();
    tick();
  endtask

  task automatic wait_cs(input string tag);
    int k = 0;
    while (!m_cs && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 32'(m_cs), 32'd1);
  endtask

  task automatic host_access(input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int exp_lat);
    int lat = 0;
    hq.push_back(hx_t'{we, we ? 16'h0000 : exp_mem(int'(a))});
    if (we) ref_wr[int'(a)] = d;
    hif.h_req   = 1'b1;
    hif.h_we    = we;
    hif.h_addr  = a;
    hif.h_wdata = d;
    while (lat < 200) begin
      tick();
      lat++;
      if (hif.h_ack) break;
    end
    hif.h_req = 1'b0;
    chk("host_lat", 32'(lat), 32'(exp_lat));
    tick();
  endtask

  initial begin
    int   exp_cnt;
    logic exp_bank;
    int   cs0;
    int   k;

    hif.h_req   = 1'b0;
    hif.h_we    = 1'b0;
    hif.h_addr  = '0;
    hif.h_wdata = '0;

    #22;
    chk("rst_m_cs",    32'(m_cs), 32'd0);
    chk("rst_m_addr",  32'(m_addr), 32'd0);
    chk("rst_lb_we",   32'(lb_we), 32'd0);
    chk("rst_lb_bank", 32'(lb_bank), 32'd0);
    chk("rst_h_ack",   32'(hif.h_ack), 32'd0);
`ifdef VGA_ARB_OVF_EN
    chk("rst_ovf",     32'(fetch_ovf), 32'd0);
`endif
    #13 rst_n = 1'b1;
    tick();

    // host write then read, no fetch pending
    host_access(1'b1, 19'h00100, 16'h1234, 2);
    host_access(1'b0, 19'h00100, 16'h0000, 2);
    host_access(1'b0, 19'h07F00, 16'h0000, 2);

    // frame start: row 0 into bank 0
    exp_bank = 1'b0;
    push_line(0, exp_bank, LW);
    pulse_vstart();
    wait_drain();
    exp_cnt = 1;

    // row 1 into bank 1
    exp_bank = ~exp_bank;
    push_line(exp_cnt * LW, exp_bank, LW);
    pulse_hstart(1'b0);
    wait_drain();
    exp_cnt++;

    // host request in the first burst cycle
    exp_bank = ~exp_bank;
    push_line(exp_cnt * LW, exp_bank, LW);
    pulse_hstart(1'b0);
    wait_cs("fetch_start");
    host_access(1'b0, 19'h00100, 16'h0000, LW + 3);
    wait_drain();
    exp_cnt++;

    // host request in the cycle the fetch is launched
    exp_bank = ~exp_bank;
    push_line(exp_cnt * LW, exp_bank, LW);
    pulse_hstart(1'b0);
    host_access(1'b0, 19'h07F01, 16'h0000, LW + 4);
    wait_drain();
    exp_cnt++;

    // vstart at word 20 aborts the burst, restarts at row 0
    exp_bank = ~exp_bank;
    push_line(exp_cnt * LW, exp_bank, 20);
    pulse_hstart(1'b0);
    k = 0;
    while (!(m_cs && m_addr == AW'(exp_cnt * LW + 20)) && k < 100) begin
      tick();
      k++;
    end
    chk("abort_reach_w20", 32'(m_cs), 32'd1);
    exp_bank = 1'b0;
    push_line(0, exp_bank, LW);
    pulse_vstart();
    chk("abort_m_cs", 32'(m_cs), 32'd0);
    chk("abort_lb_we", 32'(lb_we), 32'd0);
    wait_drain();
    exp_cnt = 1;

    // hstart outside the active region fetches nothing
    cs0 = cs_cycles;
    pulse_hstart(1'b1);
    repeat (60) tick();
    chk("vna_no_fetch", 32'(cs_cycles - cs0), 32'd0);
    chk("vna_bank", 32'(lb_bank), 32'(exp_bank));

    // rest of the frame; the count saturates after LINES rows
    for (int n = 1; n <= LINES; n++) begin
      if (exp_cnt < LINES) begin
        exp_bank = ~exp_bank;
        push_line(exp_cnt * LW, exp_bank, LW);
        pulse_hstart(1'b0);
        wait_drain();
        exp_cnt++;
      end else begin
        cs0 = cs_cycles;
        pulse_hstart(1'b0);
        repeat (60) tick();
        chk("sat_no_fetch", 32'(cs_cycles - cs0), 32'd0);
        chk("sat_bank", 32'(lb_bank), 32'(exp_bank));
      end
    end

`ifdef VGA_ARB_OVF_EN
    // overrun flag: hstart during a burst, sticky until cleared
    chk("ovf_pre", 32'(fetch_ovf), 32'd0);
    exp_bank = 1'b0;
    push_line(0, exp_bank, LW);
    pulse_vstart();
    wait_cs("ovf_fetch_start");
    pulse_hstart(1'b1);
    chk("ovf_set", 32'(fetch_ovf), 32'd1);
    wait_drain();
    repeat (5) tick();
    chk("ovf_sticky", 32'(fetch_ovf), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(fetch_ovf), 32'd0);
`endif

    chk("hq_empty", 32'(hq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
